// File: rtl/oled_seq.sv
// OLED sequencer: panel reset, fixed init command list, then host byte frames,
// all driven through an external SPI byte engine with one CS window per frame.
module oled_seq #(
    parameter int unsigned RES_LO_CYC   = 1000,
    parameter int unsigned RES_WAIT_CYC = 300000,
    parameter int unsigned GAP_CYC      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_done,
    output logic       spi_start,
    output logic       spi_stop,
    output logic       spi_write,
    output logic [7:0] spi_data,
    input  logic       host_req,
    input  logic [7:0] host_byte,
    input  logic       host_dc,
    input  logic       host_last,
    output logic       host_ready,
    input  logic       reinit,
    output logic       oled_dc,
    output logic       oled_res_n,
    output logic       init_done,
    output logic       busy
);

    localparam int unsigned MAX_A   = (RES_LO_CYC > RES_WAIT_CYC) ? RES_LO_CYC : RES_WAIT_CYC;
    localparam int unsigned CNT_MAX = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam logic [4:0]  LAST_IDX = 5'd24;

    localparam logic [3:0] S_RES_LO   = 4'd0;
    localparam logic [3:0] S_RES_WAIT = 4'd1;
    localparam logic [3:0] S_OPEN     = 4'd2;
    localparam logic [3:0] S_LOAD     = 4'd3;
    localparam logic [3:0] S_WPULSE   = 4'd4;
    localparam logic [3:0] S_WLO      = 4'd5;
    localparam logic [3:0] S_WHI      = 4'd6;
    localparam logic [3:0] S_HWAIT    = 4'd7;
    localparam logic [3:0] S_CLOSE    = 4'd8;
    localparam logic [3:0] S_IDLE     = 4'd9;

    logic [3:0]    state;
    logic [CW-1:0] cnt;
    logic [4:0]    idx;
    logic          src_host;
    logic [7:0]    hbyte;
    logic          hdc;
    logic          hlast;
    logic          host_acc;

    function automatic logic [7:0] init_rom(input logic [4:0] i);
        logic [7:0] b;
        b = 8'h00;
        case (i)
            5'd0:  b = 8'hAE;
            5'd1:  b = 8'hD5;
            5'd2:  b = 8'h80;
            5'd3:  b = 8'hA8;
            5'd4:  b = 8'h3F;
            5'd5:  b = 8'hD3;
            5'd6:  b = 8'h00;
            5'd7:  b = 8'h40;
            5'd8:  b = 8'h8D;
            5'd9:  b = 8'h14;
            5'd10: b = 8'h20;
            5'd11: b = 8'h00;
            5'd12: b = 8'hA1;
            5'd13: b = 8'hC8;
            5'd14: b = 8'hDA;
            5'd15: b = 8'h12;
            5'd16: b = 8'h81;
            5'd17: b = 8'hCF;
            5'd18: b = 8'hD9;
            5'd19: b = 8'hF1;
            5'd20: b = 8'hDB;
            5'd21: b = 8'h40;
            5'd22: b = 8'hA4;
            5'd23: b = 8'hA6;
            5'd24: b = 8'hAF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Start/stop pulse on the first cycle of their state; cnt is zero on entry.
    assign spi_start  = (state == S_OPEN) && (cnt == '0);
    assign spi_stop   = (state == S_CLOSE) && (cnt == '0);
    assign spi_write  = (state == S_WPULSE);
    // reinit wins over a host byte in IDLE, so the handshake is withheld then.
    assign host_ready = (state == S_HWAIT) || ((state == S_IDLE) && !reinit);
    assign host_acc   = host_req && host_ready;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_RES_LO;
            cnt        <= '0;
            idx        <= '0;
            src_host   <= 1'b0;
            hbyte      <= 8'h00;
            hdc        <= 1'b0;
            hlast      <= 1'b0;
            spi_data   <= 8'h00;
            oled_dc    <= 1'b0;
            oled_res_n <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            case (state)
                S_RES_LO: begin
                    if (cnt == CW'(RES_LO_CYC - 1)) begin
                        oled_res_n <= 1'b1;
                        cnt        <= '0;
                        state      <= S_RES_WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RES_WAIT: begin
                    if (cnt == CW'(RES_WAIT_CYC - 1)) begin
                        cnt      <= '0;
                        idx      <= '0;
                        src_host <= 1'b0;
                        state    <= S_OPEN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_OPEN: begin
                    if (cnt == '0) begin
                        cnt <= CW'(1);
                    end else if (spi_done) begin
                        cnt   <= '0;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    spi_data <= src_host ? hbyte : init_rom(idx);
                    oled_dc  <= src_host ? hdc : 1'b0;
                    state    <= S_WPULSE;
                end
                S_WPULSE: state <= S_WLO;
                S_WLO: begin
                    if (!spi_done) state <= S_WHI;
                end
                S_WHI: begin
                    if (spi_done) begin
                        if (!src_host) begin
                            if (idx == LAST_IDX) begin
                                state <= S_CLOSE;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= S_LOAD;
                            end
                        end else if (hlast) begin
                            state <= S_CLOSE;
                        end else begin
                            state <= S_HWAIT;
                        end
                    end
                end
                S_HWAIT: begin
                    if (host_acc) begin
                        hbyte <= host_byte;
                        hdc   <= host_dc;
                        hlast <= host_last;
                        state <= S_LOAD;
                    end
                end
                S_CLOSE: begin
                    if (cnt == CW'(GAP_CYC)) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                        if (!src_host) init_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (reinit) begin
                        init_done  <= 1'b0;
                        oled_res_n <= 1'b0;
                        cnt        <= '0;
                        state      <= S_RES_LO;
                    end else if (host_acc) begin
                        hbyte    <= host_byte;
                        hdc      <= host_dc;
                        hlast    <= host_last;
                        src_host <= 1'b1;
                        cnt      <= '0;
                        state    <= S_OPEN;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_RES_LO;
                end
            endcase
        end
    end

endmodule
